// File: rtl/coalescing_store_unit.sv
// Coalescing store buffer: checks, lane-aligns and queues stores,
// merges same-word writes, drains committed entries, forwards to loads.
module coalescing_store_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 8,
  parameter logic [XLEN-1:0] PRIV_START = '0,
  parameter logic [XLEN-1:0] PRIV_END = XLEN'(32'h0000_0FFF)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              privilege_i,
  input  logic              valid_operation_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [XLEN-1:0]   store_address_i,
  input  logic [1:0]        width_i,
  input  logic              validate_i,
  input  logic [XLEN-1:0]   foward_address_i,
  output logic [XLEN-1:0]   foward_data_o,
  output logic [XLEN/8-1:0] foward_bytes_o,
  output logic              foward_match_o,
  output logic              mem_request_o,
  output logic [XLEN-1:0]   mem_address_o,
  output logic [XLEN-1:0]   mem_data_o,
  output logic [XLEN/8-1:0] mem_byte_en_o,
  input  logic              mem_done_i,
  output logic              idle_o,
  output logic              buffer_empty_o,
  output logic              buffer_full_o,
  output logic              data_valid_o,
  output logic              illegal_access_o,
  output logic              misaligned_o
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = XLEN - OW;

  typedef enum logic {IDLE, WAIT_BUFFER} state_t;

  state_t state_q, state_d;
  logic [XLEN-1:0] hold_addr_q, hold_data_q;
  logic [1:0] hold_width_q;

  logic [AW-1:0] e_addr [DEPTH];
  logic [XLEN-1:0] e_data [DEPTH];
  logic [NB-1:0] e_be [DEPTH];
  logic [7:0] e_mcnt [DEPTH];
  logic [DEPTH-1:0] e_used, e_val;

  logic [PW-1:0] head_q, tail_q, vptr_q, yng, fidx;
  logic [PW:0] count_q, vcount_q, vcount_n;

  logic in_idle;
  logic [XLEN-1:0] op_addr, op_data, size_mask, bmask, op_sdata;
  logic [1:0] op_width;
  logic [OW-1:0] off;
  logic [AW-1:0] op_waddr, fwaddr;
  logic [7:0] ones;
  logic [NB-1:0] op_be;
  logic misal, illegal, fault, attempt;
  logic can_coal, full, do_coal, do_push, success;
  logic pop, vok, coal_v, vdone;
  logic dv_q, ill_q, mis_q;
  logic unused_fwd;

  assign in_idle  = state_q == IDLE;
  assign op_addr  = in_idle ? store_address_i : hold_addr_q;
  assign op_data  = in_idle ? store_data_i : hold_data_q;
  assign op_width = in_idle ? width_i : hold_width_q;
  assign off      = op_addr[OW-1:0];
  assign op_waddr = op_addr[XLEN-1:OW];

  always_comb begin
    size_mask = '0;
    ones = 8'h01;
    unique case (op_width)
      2'd0: begin size_mask = '0;        ones = 8'h01; end
      2'd1: begin size_mask = XLEN'(1);  ones = 8'h03; end
      2'd2: begin size_mask = XLEN'(3);  ones = 8'h0F; end
      default: begin size_mask = XLEN'(7); ones = 8'hFF; end
    endcase
  end

  assign op_be = NB'(ones) << off;

  always_comb begin
    bmask = '0;
    for (int b = 0; b < NB; b++) bmask[8*b +: 8] = {8{op_be[b]}};
  end

  assign op_sdata = (op_data << {off, 3'b000}) & bmask;

  assign misal = (|(op_addr & size_mask)) ||
                 (XLEN == 32 && op_width == 2'd3);
  // Range test by offset subtraction avoids an always-true compare at 0
  assign illegal = !privilege_i &&
    ((op_addr - PRIV_START) <= (PRIV_END - PRIV_START));

  assign fault   = in_idle && valid_operation_i && (misal || illegal);
  assign attempt = in_idle ? (valid_operation_i && !misal && !illegal) : 1'b1;

  assign yng      = tail_q - PW'(1);
  assign full     = count_q == (PW+1)'(DEPTH);
  assign can_coal = (count_q != '0) && !e_val[yng] &&
                    (e_addr[yng] == op_waddr) &&
                    !(yng == head_q && mem_request_o);
  assign do_coal  = attempt && can_coal && !flush_i;
  assign do_push  = attempt && !can_coal && !full && !flush_i;
  assign success  = do_coal || do_push;

  assign pop    = mem_request_o && mem_done_i;
  assign vok    = validate_i && e_used[vptr_q] && !e_val[vptr_q];
  assign coal_v = do_coal && (yng == vptr_q);
  assign vdone  = vok && !coal_v && (e_mcnt[vptr_q] == 8'd1);
  assign vcount_n = vcount_q + (PW+1)'(vdone) - (PW+1)'(pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = IDLE;
    else if (in_idle && attempt && !success) state_d = WAIT_BUFFER;
    else if (!in_idle && success) state_d = IDLE;
  end

  always_comb begin
    idle_o = state_q == IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_width_q <= '0;
      dv_q  <= 1'b0;
      ill_q <= 1'b0;
      mis_q <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      vptr_q   <= '0;
      count_q  <= '0;
      vcount_q <= '0;
      e_used   <= '0;
      e_val    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_be[i]   <= '0;
        e_mcnt[i] <= '0;
      end
    end else begin
      if (in_idle && state_d == WAIT_BUFFER) begin
        hold_addr_q  <= store_address_i;
        hold_data_q  <= store_data_i;
        hold_width_q <= width_i;
      end
      dv_q  <= fault || success;
      ill_q <= fault && illegal;
      mis_q <= fault && misal;
      head_q   <= head_q + PW'(pop);
      vptr_q   <= vptr_q + PW'(vdone);
      vcount_q <= vcount_n;
      tail_q   <= flush_i ? vptr_q + PW'(vdone) : tail_q + PW'(do_push);
      count_q  <= flush_i ? vcount_n
                          : count_q + (PW+1)'(do_push) - (PW+1)'(pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && tail_q == PW'(i)) begin
          e_used[i] <= 1'b1;
          e_val[i]  <= 1'b0;
          e_mcnt[i] <= 8'd1;
          e_addr[i] <= op_waddr;
          e_data[i] <= op_sdata;
          e_be[i]   <= op_be;
        end else begin
          if (do_coal && yng == PW'(i)) begin
            e_data[i] <= (e_data[i] & ~bmask) | op_sdata;
            e_be[i]   <= e_be[i] | op_be;
          end
          // One validate is owed per merged store
          e_mcnt[i] <= e_mcnt[i] + 8'(do_coal && yng == PW'(i))
                                 - 8'(vok && vptr_q == PW'(i));
          if (vdone && vptr_q == PW'(i)) e_val[i] <= 1'b1;
          if (pop && head_q == PW'(i)) begin
            e_used[i] <= 1'b0;
            e_val[i]  <= 1'b0;
          end else if (flush_i && e_used[i] && !e_val[i] &&
                       !(vdone && vptr_q == PW'(i))) begin
            e_used[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign mem_request_o  = e_used[head_q] && e_val[head_q];
  assign mem_address_o  = mem_request_o ? {e_addr[head_q], {OW{1'b0}}} : '0;
  assign mem_data_o     = mem_request_o ? e_data[head_q] : '0;
  assign mem_byte_en_o  = mem_request_o ? e_be[head_q] : '0;
  assign buffer_empty_o = count_q == '0;
  assign buffer_full_o  = full;
  assign data_valid_o   = dv_q;
  assign illegal_access_o = ill_q;
  assign misaligned_o   = mis_q;

  assign fwaddr = foward_address_i[XLEN-1:OW];
  assign unused_fwd = ^foward_address_i[OW-1:0];

  // Walk oldest to youngest so younger entries override per lane
  always_comb begin
    foward_data_o  = '0;
    foward_bytes_o = '0;
    fidx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = head_q + PW'(k);
      if ((PW+1)'(k) < count_q && e_used[fidx] && e_addr[fidx] == fwaddr) begin
        for (int b = 0; b < NB; b++) begin
          if (e_be[fidx][b]) begin
            foward_data_o[8*b +: 8] = e_data[fidx][8*b +: 8];
            foward_bytes_o[b] = 1'b1;
          end
        end
      end
    end
  end

  assign foward_match_o = |foward_bytes_o;

endmodule

// File: tb/tb_coalescing_store_unit.sv
// Directed bench for coalescing_store_unit, XLEN=32 and XLEN=64.
module tb_coalescing_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic flush, priv, vop, validate, mdone;
  logic [31:0] sdata, saddr, faddr;
  logic [1:0] width;
  logic [31:0] fdata, maddr, mdata;
  logic [3:0] fbytes, mbe;
  logic fmatch, mreq, idle, empty, full, dv, ill, mis;

  logic flush_w, priv_w, vop_w, validate_w, mdone_w;
  logic [63:0] sdata_w, saddr_w, faddr_w;
  logic [1:0] width_w;
  logic [63:0] fdata_w, maddr_w, mdata_w;
  logic [7:0] fbytes_w, mbe_w;
  logic fmatch_w, mreq_w, idle_w, empty_w, full_w, dv_w, ill_w, mis_w;

  coalescing_store_unit u32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .privilege_i(priv),
    .valid_operation_i(vop), .store_data_i(sdata), .store_address_i(saddr),
    .width_i(width), .validate_i(validate), .foward_address_i(faddr),
    .foward_data_o(fdata), .foward_bytes_o(fbytes), .foward_match_o(fmatch),
    .mem_request_o(mreq), .mem_address_o(maddr), .mem_data_o(mdata),
    .mem_byte_en_o(mbe), .mem_done_i(mdone), .idle_o(idle),
    .buffer_empty_o(empty), .buffer_full_o(full), .data_valid_o(dv),
    .illegal_access_o(ill), .misaligned_o(mis)
  );

  coalescing_store_unit #(.XLEN(64)) u64 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush_w), .privilege_i(priv_w),
    .valid_operation_i(vop_w), .store_data_i(sdata_w),
    .store_address_i(saddr_w), .width_i(width_w), .validate_i(validate_w),
    .foward_address_i(faddr_w), .foward_data_o(fdata_w),
    .foward_bytes_o(fbytes_w), .foward_match_o(fmatch_w),
    .mem_request_o(mreq_w), .mem_address_o(maddr_w), .mem_data_o(mdata_w),
    .mem_byte_en_o(mbe_w), .mem_done_i(mdone_w), .idle_o(idle_w),
    .buffer_empty_o(empty_w), .buffer_full_o(full_w), .data_valid_o(dv_w),
    .illegal_access_o(ill_w), .misaligned_o(mis_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] w);
    saddr = a; sdata = d; width = w; vop = 1'b1;
    tick();
    vop = 1'b0;
  endtask

  task automatic store64(input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] w);
    saddr_w = a; sdata_w = d; width_w = w; vop_w = 1'b1;
    tick();
    vop_w = 1'b0;
  endtask

  task automatic test_reset();
    flush = 0; priv = 0; vop = 0; validate = 0; mdone = 0;
    sdata = 0; saddr = 0; faddr = 0; width = 0;
    flush_w = 0; priv_w = 0; vop_w = 0; validate_w = 0; mdone_w = 0;
    sdata_w = 0; saddr_w = 0; faddr_w = 0; width_w = 0;
    rst_n = 1'b0;
    #1;
    checks++; if (idle !== 1'b1) begin errs++; $display("FAIL reset_idle got %b want 1", idle); end
    checks++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if ({mreq, dv, full, fmatch} !== 4'b0000) begin errs++; $display("FAIL reset_outs got %b want 0000", {mreq, dv, full, fmatch}); end
    checks++; if ({idle_w, empty_w, mreq_w} !== 3'b110) begin errs++; $display("FAIL reset_64 got %b want 110", {idle_w, empty_w, mreq_w}); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_drain();
    store(32'h1000, 32'hDEADBEEF, 2'd2);
    checks++; if ({dv, mis, ill} !== 3'b100) begin errs++; $display("FAIL drain_dv got %b want 100", {dv, mis, ill}); end
    checks++; if (mreq !== 1'b0) begin errs++; $display("FAIL drain_noreq got %b want 0", mreq); end
    validate = 1; tick(); validate = 0;
    checks++; if (mreq !== 1'b1) begin errs++; $display("FAIL drain_req1 got %b want 1", mreq); end
    checks++; if (maddr !== 32'h1000) begin errs++; $display("FAIL drain_addr got %h want 00001000", maddr); end
    checks++; if (mbe !== 4'b1111) begin errs++; $display("FAIL drain_be got %b want 1111", mbe); end
    checks++; if (mdata !== 32'hDEADBEEF) begin errs++; $display("FAIL drain_data got %h want deadbeef", mdata); end
    tick();
    checks++; if (mreq !== 1'b1) begin errs++; $display("FAIL drain_req2 got %b want 1", mreq); end
    mdone = 1; tick(); mdone = 0;
    checks++; if ({mreq, empty} !== 2'b01) begin errs++; $display("FAIL drain_done got %b want 01", {mreq, empty}); end
  endtask

  task automatic test_coalesce();
    store(32'h2001, 32'h000000AA, 2'd0);
    store(32'h2003, 32'h000000BB, 2'd0);
    checks++; if (dv !== 1'b1) begin errs++; $display("FAIL coal_dv got %b want 1", dv); end
    faddr = 32'h2000; #1;
    checks++; if (fbytes !== 4'b1010) begin errs++; $display("FAIL coal_fbytes got %b want 1010", fbytes); end
    checks++; if (fmatch !== 1'b1) begin errs++; $display("FAIL coal_fmatch got %b want 1", fmatch); end
    checks++; if (fdata !== 32'hBB00AA00) begin errs++; $display("FAIL coal_fdata got %h want bb00aa00", fdata); end
    validate = 1; tick(); validate = 0;
    checks++; if (mreq !== 1'b0) begin errs++; $display("FAIL coal_mcnt got %b want 0", mreq); end
    validate = 1; tick(); validate = 0;
    checks++; if ({mreq, mbe, mdata} !== {1'b1, 4'b1010, 32'hBB00AA00}) begin errs++; $display("FAIL coal_drain got %b %b %h want 1 1010 bb00aa00", mreq, mbe, mdata); end
    mdone = 1; tick(); mdone = 0;
    checks++; if (empty !== 1'b1) begin errs++; $display("FAIL coal_single got %b want 1", empty); end
  endtask

  task automatic test_faults();
    store(32'h2001, 32'h1234, 2'd1);
    checks++; if ({dv, mis, ill, empty} !== 4'b1101) begin errs++; $display("FAIL misal_sh got %b want 1101", {dv, mis, ill, empty}); end
    store(32'h3000, 32'h0, 2'd3);
    checks++; if ({dv, mis, empty} !== 3'b111) begin errs++; $display("FAIL misal_sd32 got %b want 111", {dv, mis, empty}); end
    priv = 0;
    store(32'h0010, 32'h55, 2'd2);
    checks++; if ({dv, mis, ill, empty} !== 4'b1011) begin errs++; $display("FAIL illegal got %b want 1011", {dv, mis, ill, empty}); end
    priv = 1;
    store(32'h0010, 32'h55, 2'd2);
    priv = 0;
    checks++; if ({dv, mis, ill, empty} !== 4'b1000) begin errs++; $display("FAIL priv_ok got %b want 1000", {dv, mis, ill, empty}); end
    validate = 1; tick(); validate = 0;
    checks++; if (maddr !== 32'h10) begin errs++; $display("FAIL priv_addr got %h want 00000010", maddr); end
    mdone = 1; tick(); mdone = 0;
    checks++; if (empty !== 1'b1) begin errs++; $display("FAIL priv_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) store(32'h3000 + 32'(4 * i), 32'(i), 2'd2);
    checks++; if (full !== 1'b1) begin errs++; $display("FAIL fill_full got %b want 1", full); end
    store(32'h4000, 32'h99, 2'd2);
    checks++; if ({idle, dv} !== 2'b00) begin errs++; $display("FAIL wait_enter got %b want 00", {idle, dv}); end
    tick();
    checks++; if (idle !== 1'b0) begin errs++; $display("FAIL wait_hold got %b want 0", idle); end
    validate = 1; tick(); validate = 0;
    checks++; if ({mreq, maddr} !== {1'b1, 32'h3000}) begin errs++; $display("FAIL wait_req got %b %h want 1 00003000", mreq, maddr); end
    mdone = 1; tick(); mdone = 0;
    checks++; if ({idle, full, dv} !== 3'b000) begin errs++; $display("FAIL wait_pop got %b want 000", {idle, full, dv}); end
    tick();
    checks++; if ({idle, full, dv} !== 3'b111) begin errs++; $display("FAIL wait_push got %b want 111", {idle, full, dv}); end
    faddr = 32'h4000; #1;
    checks++; if ({fbytes, fdata} !== {4'b1111, 32'h99}) begin errs++; $display("FAIL wait_fwd got %b %h want 1111 00000099", fbytes, fdata); end
    flush = 1; tick(); flush = 0;
    checks++; if (empty !== 1'b1) begin errs++; $display("FAIL fill_flush got %b want 1", empty); end
  endtask

  task automatic test_flush();
    store(32'h5000, 32'h1, 2'd2);
    store(32'h5004, 32'h2, 2'd2);
    store(32'h5008, 32'h3, 2'd2);
    validate = 1; tick(); validate = 0;
    flush = 1; tick(); flush = 0;
    checks++; if ({empty, mreq, maddr} !== {1'b0, 1'b1, 32'h5000}) begin errs++; $display("FAIL flush_keep got %b %b %h want 0 1 00005000", empty, mreq, maddr); end
    faddr = 32'h5004; #1;
    checks++; if (fmatch !== 1'b0) begin errs++; $display("FAIL flush_drop got %b want 0", fmatch); end
    faddr = 32'h5000; #1;
    checks++; if (fmatch !== 1'b1) begin errs++; $display("FAIL flush_hit got %b want 1", fmatch); end
    mdone = 1; tick(); mdone = 0;
    checks++; if ({empty, mreq} !== 2'b10) begin errs++; $display("FAIL flush_drain got %b want 10", {empty, mreq}); end
  endtask

  task automatic test_xlen64();
    priv_w = 1;
    store64(64'h8, 64'h1122334455667788, 2'd3);
    checks++; if ({dv_w, mis_w} !== 2'b10) begin errs++; $display("FAIL x64_sd_dv got %b want 10", {dv_w, mis_w}); end
    faddr_w = 64'h8; #1;
    checks++; if ({fbytes_w, fdata_w} !== {8'hFF, 64'h1122334455667788}) begin errs++; $display("FAIL x64_sd got %h %h want ff 1122334455667788", fbytes_w, fdata_w); end
    store64(64'h4, 64'hCAFEF00D, 2'd2);
    faddr_w = 64'h0; #1;
    checks++; if ({fbytes_w, fdata_w} !== {8'hF0, 64'hCAFEF00D_00000000}) begin errs++; $display("FAIL x64_sw got %h %h want f0 cafef00d00000000", fbytes_w, fdata_w); end
    store64(64'hC, 64'h0, 2'd3);
    checks++; if ({dv_w, mis_w} !== 2'b11) begin errs++; $display("FAIL x64_misal got %b want 11", {dv_w, mis_w}); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_coalesce();
    test_faults();
    test_back_to_back();
    test_flush();
    test_xlen64();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/coalescing_store_unit.md
Name: coalescing_store_unit

Overview:
- Parametrised successor to the current store unit.
- Receives store micro-ops from the memory issue stage and checks alignment and private-region privilege.
- Lane-aligns data into byte lanes, generates byte enables and buffers stores in an internal DEPTH-entry FIFO.
- Coalesces a new store into the youngest pending entry when it hits the same word. Drains only commit-validated entries to the memory controller.
- Forwards buffered data to loads per byte.

Parameters:
- XLEN, 32, data/address width; 32 or 64.
- DEPTH, 8, store buffer entries; power of 2, at least 2.
- PRIV_START, 32'h0000_0000, first address of the machine-only region.
- PRIV_END, 32'h0000_0FFF, last address of the machine-only region, inclusive.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discard unvalidated entries and any held operation.
- privilege_i  in  1  1 = machine mode.
- valid_operation_i  in  1  store operation present.
- store_data_i  in  XLEN  store data, LSB-justified.
- store_address_i  in  XLEN  byte address.
- width_i  in  2  store width: 0 byte, 1 half, 2 word, 3 double (XLEN=64 only).
- validate_i  in  1  mark oldest unvalidated entry committed.
- foward_address_i  in  XLEN  load address for forwarding.
- foward_data_o  out  XLEN  forwarded word, lane-aligned.
- foward_bytes_o  out  XLEN/8  bytes supplied by the buffer.
- foward_match_o  out  1  any byte supplied.
- mem_request_o  out  1  write request to memory controller.
- mem_address_o  out  XLEN  word-aligned address.
- mem_data_o  out  XLEN  write data.
- mem_byte_en_o  out  XLEN/8  byte enables.
- mem_done_i  in  1  controller accepted the current write.
- idle_o  out  1  unit can accept an operation.
- buffer_empty_o  out  1  no entries.
- buffer_full_o  out  1  DEPTH entries.
- data_valid_o  out  1  result/exception valid (one-cycle pulse).
- illegal_access_o  out  1  privilege violation; qualified by data_valid_o.
- misaligned_o  out  1  misaligned address; qualified by data_valid_o.

Behaviour:
- Reset values: all outputs 0, except idle_o=1 and buffer_empty_o=1. FIFO pointers, count and valid bits are cleared, and the FSM goes to IDLE.
- Definitions: OFF = address[log2(XLEN/8)-1:0]; word address = address >> log2(XLEN/8).
- Misaligned when the address is not a multiple of the access size (1/2/4/8 bytes). width_i=3 with XLEN=32 is also misaligned.
- Illegal when PRIV_START <= address <= PRIV_END and privilege_i=0.
- Byte enables: 2^width ones shifted left by OFF. Data is shifted left by 8*OFF.
- Entry contents: word address, data, byte enables, validated bit.
- FSM has two states, IDLE and WAIT_BUFFER.
- IDLE, valid_operation_i=1:
  - Faulting operation: nothing is pushed. Next cycle: data_valid_o=1 with the flags registered.
  - Coalesce case: youngest entry exists, is unvalidated, has the same word address, and is not the head being drained (mem_request_o=1). The new bytes overwrite the matching lanes and byte enables are ORed. Count is unchanged. data_valid_o pulses next cycle.
  - Otherwise, if not full: push. data_valid_o pulses next cycle.
  - If full: latch the operation and go to WAIT_BUFFER; idle_o=0.
- WAIT_BUFFER: retry (coalesce or push) with the latched operation each cycle. On success, data_valid_o pulses next cycle and the FSM returns to IDLE. Upstream must not assert valid_operation_i while idle_o=0.
- Full is evaluated on the current count. A pop in the same cycle does not free space for a push until the next cycle.
- validate_i advances a validate pointer and sets that entry's validated bit. A coalesced entry keeps one validate per merged operation: each entry carries a merge count, decremented per validate_i, and becomes validated at 0.
- Drain: when the head is validated, mem_request_o=1 with address, data and byte enables from the head, held stable until mem_done_i. On mem_done_i the head is popped, and mem_request_o may re-assert the next cycle.
- Flush: the FSM returns to IDLE, the held operation is dropped, and all unvalidated entries are removed (tail := validate pointer). Validated entries keep draining. Flush takes priority over a same-cycle push.
- Forwarding (combinational): for each byte lane, take the youngest entry with matching word address and that lane enabled. foward_bytes_o is the OR of the enabled lanes; foward_match_o = |foward_bytes_o.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Asynchronous reset mid-drain drops the request immediately.

Test Plan:
- XLEN=32, reset; SW 0xDEADBEEF @0x1000, validate_i; mem_done_i on the 2nd request cycle -> mem_request_o for 2 cycles, addr 0x1000, be 4'b1111, data 0xDEADBEEF; then buffer_empty_o=1.
- SB 0xAA @0x2001, then SB 0xBB @0x2003, unvalidated -> single entry with be 4'b1010 and data 0xBB00AA00. Load forward @0x2000 -> foward_bytes_o=4'b1010, foward_match_o=1.
- SH @0x2001 -> data_valid_o=1, misaligned_o=1, no push. SW @0x0010 with privilege_i=0 -> illegal_access_o=1. Same with privilege_i=1 -> pushed.
- Fill 8 distinct words, none validated; 9th store -> idle_o=0, WAIT_BUFFER. Then validate_i + mem_done_i -> the held store is pushed the cycle after the pop, with data_valid_o pulsing.
- 3 entries, first validated; flush_i -> count 1; the validated entry still drains and buffer_empty_o=1 afterwards.
- XLEN=64: SD @0x8 with OFF=0 -> be 8'hFF. SW @0x4 -> be 8'hF0, data shifted 32 bits.
